// File: rtl/mem_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_cmd_arbiter_if
// Brief    : Requester and controller command bus of the DDR command arbiter.
// Revision : 1.0
// ============================================================================
interface mem_cmd_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int PID_W     = 2
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*3-1:0]      req_type;
    logic [NUM_PORTS-1:0]        req_ready;
    logic                        cmd_valid;
    logic [ADDR_W-1:0]           cmd_addr;
    logic [2:0]                  cmd_type;
    logic                        cmd_ready;
    logic [PID_W-1:0]            grant_id;

    modport master (
        input  req_valid, req_addr, req_type, cmd_ready,
        output req_ready, cmd_valid, cmd_addr, cmd_type, grant_id
    );

    modport slave (
        output req_valid, req_addr, req_type, cmd_ready,
        input  req_ready, cmd_valid, cmd_addr, cmd_type, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/mem_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_cmd_arbiter
// Brief    : Round-robin command arbiter with periodic auto-refresh injection.
// Revision : 1.0
// ============================================================================
module mem_cmd_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_W       = 32,
    parameter int REF_INTERVAL = 256,
    parameter int PID_W        = 2
) (
    input  wire                sys_clk,
    input  wire                rst_n,
    input  wire                init_done,
    mem_cmd_arbiter_if.master  bus,
    output logic               refresh_pending,
    output logic [1:0]         err
);
    localparam int         c_TIMER_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [1:0] c_INIT    = 2'd0;
    localparam logic [1:0] c_IDLE    = 2'd1;
    localparam logic [1:0] c_ISSUE   = 2'd2;

    logic [1:0]           r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [PID_W-1:0]     r_rr_ptr;
    logic [PID_W-1:0]     r_grant_id;
    logic                 r_pending;
    logic                 r_is_refresh;
    logic                 r_cmd_valid;
    logic [ADDR_W-1:0]    r_cmd_addr;
    logic [2:0]           r_cmd_type;
    logic [1:0]           r_err;

    logic                 w_found;
    logic [PID_W-1:0]     w_sel;
    logic                 w_accept;
    logic                 w_wrap;
    logic                 w_ref_done;
    logic [2:0]           w_sel_type;
    logic [ADDR_W-1:0]    w_sel_addr;

    // Descending scan so the port nearest after the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (bus.req_valid[(int'(r_rr_ptr) + k) % NUM_PORTS]) begin
                w_found = 1'b1;
                w_sel   = PID_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
            end
        end
    end

    assign w_accept   = (r_state == c_IDLE) && init_done && !r_pending && w_found;
    assign w_sel_type = bus.req_type[int'(w_sel)*3 +: 3];
    assign w_sel_addr = bus.req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
    assign w_wrap     = (r_state != c_INIT) && (r_timer == c_TIMER_W'(REF_INTERVAL - 1));
    assign w_ref_done = (r_state == c_ISSUE) && r_is_refresh && bus.cmd_ready;

    assign bus.req_ready   = w_accept ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << w_sel) : '0;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_addr    = r_cmd_addr;
    assign bus.cmd_type    = r_cmd_type;
    assign bus.grant_id    = r_grant_id;
    assign refresh_pending = r_pending;
    assign err             = r_err;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_INIT;
            r_timer      <= '0;
            r_rr_ptr     <= PID_W'(NUM_PORTS - 1);
            r_grant_id   <= '0;
            r_pending    <= 1'b0;
            r_is_refresh <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_type   <= '0;
            r_err        <= '0;
        end else begin
            if (r_state == c_INIT) begin
                r_timer   <= '0;
                r_pending <= 1'b0;
            end else begin
                r_timer <= w_wrap ? '0 : r_timer + c_TIMER_W'(1);
                // A wrap coinciding with the refresh handshake re-arms without overflow.
                if (w_wrap) begin
                    r_pending <= 1'b1;
                    if (r_pending && !w_ref_done) r_err[0] <= 1'b1;
                end else if (w_ref_done) begin
                    r_pending <= 1'b0;
                end
            end

            case (r_state)
                c_INIT: begin
                    if (init_done) r_state <= c_IDLE;
                end
                c_IDLE: begin
                    if (!init_done) begin
                        r_state <= c_INIT;
                    end else if (r_pending) begin
                        r_cmd_addr   <= '0;
                        r_cmd_type   <= 3'b010;
                        r_grant_id   <= '0;
                        r_is_refresh <= 1'b1;
                        r_cmd_valid  <= 1'b1;
                        r_state      <= c_ISSUE;
                    end else if (w_found) begin
                        r_rr_ptr <= w_sel;
                        if (w_sel_type > 3'b010) begin
                            r_err[1] <= 1'b1;
                        end else begin
                            r_cmd_addr   <= w_sel_addr;
                            r_cmd_type   <= w_sel_type;
                            r_grant_id   <= w_sel;
                            r_is_refresh <= 1'b0;
                            r_cmd_valid  <= 1'b1;
                            r_state      <= c_ISSUE;
                        end
                    end
                end
                c_ISSUE: begin
                    if (bus.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= init_done ? c_IDLE : c_INIT;
                    end
                end
                default: r_state <= c_INIT;
            endcase
        end
    end
endmodule
`default_nettype wire
